// File: rtl/code_defs_pkg.sv
// code_defs_pkg: 64b/66b sync headers, block types, XGMII characters and TX encoder helpers
package code_defs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_O4   = 8'h2D;
    localparam logic [7:0] BT_S4   = 8'h33;
    localparam logic [7:0] BT_O0S4 = 8'h66;
    localparam logic [7:0] BT_O0O4 = 8'h55;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_O0   = 8'h4B;
    localparam logic [7:0] BT_T0   = 8'h87;
    localparam logic [7:0] BT_T1   = 8'h99;
    localparam logic [7:0] BT_T2   = 8'hAA;
    localparam logic [7:0] BT_T3   = 8'hB4;
    localparam logic [7:0] BT_T4   = 8'hCC;
    localparam logic [7:0] BT_T5   = 8'hD2;
    localparam logic [7:0] BT_T6   = 8'hE1;
    localparam logic [7:0] BT_T7   = 8'hFF;
    localparam logic [63:0] BT_T_ALL = {BT_T7, BT_T6, BT_T5, BT_T4, BT_T3, BT_T2, BT_T1, BT_T0};

    localparam logic [7:0] RS_IDLE  = 8'h07;
    localparam logic [7:0] RS_LPI   = 8'h06;
    localparam logic [7:0] RS_START = 8'hFB;
    localparam logic [7:0] RS_TERM  = 8'hFD;
    localparam logic [7:0] RS_ERROR = 8'hFE;
    localparam logic [7:0] RS_SEQ   = 8'h9C;
    localparam logic [7:0] RS_SIG   = 8'h5C;
    localparam logic [7:0] RS_RES0  = 8'h1C;
    localparam logic [7:0] RS_RES1  = 8'h3C;
    localparam logic [7:0] RS_RES2  = 8'h7C;
    localparam logic [7:0] RS_RES3  = 8'hBC;
    localparam logic [7:0] RS_RES4  = 8'hDC;
    localparam logic [7:0] RS_RES5  = 8'hF7;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_LPI   = 7'h06;
    localparam logic [6:0] CC_ERROR = 7'h1E;
    localparam logic [6:0] CC_RES0  = 7'h2D;
    localparam logic [6:0] CC_RES1  = 7'h33;
    localparam logic [6:0] CC_RES2  = 7'h4B;
    localparam logic [6:0] CC_RES3  = 7'h55;
    localparam logic [6:0] CC_RES4  = 7'h66;
    localparam logic [6:0] CC_RES5  = 7'h78;

    localparam logic [3:0] OC_SEQ = 4'h0;
    localparam logic [3:0] OC_SIG = 4'hF;

    localparam logic [63:0] EBLOCK_T = {{8{CC_ERROR}}, BT_IDLE};

    typedef enum logic [2:0] {T_C, T_S, T_D, T_T, T_E} t_type_t;
    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;

    // {valid, 7-bit control code}; valid=0 for characters with no control-code mapping
    function automatic logic [7:0] rs_to_control_code(input logic [7:0] c);
        case (c)
            RS_IDLE:  return {1'b1, CC_IDLE};
            RS_LPI:   return {1'b1, CC_LPI};
            RS_ERROR: return {1'b1, CC_ERROR};
            RS_RES0:  return {1'b1, CC_RES0};
            RS_RES1:  return {1'b1, CC_RES1};
            RS_RES2:  return {1'b1, CC_RES2};
            RS_RES3:  return {1'b1, CC_RES3};
            RS_RES4:  return {1'b1, CC_RES4};
            RS_RES5:  return {1'b1, CC_RES5};
            default:  return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] rs_to_cc_ocode(input logic [7:0] c);
        return (c == RS_SIG) ? OC_SIG : OC_SEQ;
    endfunction

    function automatic logic [7:0] bt_term(input logic [2:0] n);
        return BT_T_ALL[8*n +: 8];
    endfunction

endpackage

// File: rtl/encode_6466b_classify.sv
// encode_6466b_classify: combinational XGMII word -> block type class, 64-bit payload and sync header
module encode_6466b_classify
    import code_defs_pkg::*;
(
    input  logic [63:0] i_txd,
    input  logic [7:0]  i_txctl,
    output t_type_t     o_type,
    output logic [63:0] o_payload,
    output logic [1:0]  o_header
);

    logic [7:0]  w_code [8];
    logic [7:0]  w_cc_ok;
    logic [7:0]  w_term;
    logic [55:0] w_cc;
    logic        w_t_ok;
    logic [2:0]  w_tn;
    logic [63:0] w_t_pl;
    logic        w_d, w_c, w_lo4, w_o4, w_s4, w_o0, w_o0o4, w_o0s4, w_s0;
    logic [3:0]  w_oc0, w_oc4;

    // Per-lane control-code mapping plus terminate detection and Tn payload assembly
    always_comb begin
        w_t_ok = 1'b0;
        w_tn   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_code[i]      = rs_to_control_code(i_txd[8*i +: 8]);
            w_cc_ok[i]     = i_txctl[i] & w_code[i][7];
            w_term[i]      = i_txctl[i] & (i_txd[8*i +: 8] == RS_TERM);
            w_cc[7*i +: 7] = w_code[i][6:0];
        end
        for (int n = 0; n < 8; n++)
            if ((i_txctl == (8'hFF << n)) && w_term[n] && (&(w_cc_ok | ~(8'hFE << n)))) begin
                w_t_ok = 1'b1;
                w_tn   = 3'(n);
            end
        w_t_pl = {56'h0, bt_term(w_tn)};
        for (int i = 0; i < 7; i++)
            if (i < int'(w_tn)) w_t_pl[8+8*i +: 8] = i_txd[8*i +: 8];
        for (int i = 1; i < 8; i++)
            if (i > int'(w_tn)) w_t_pl[8+7*i +: 7] = w_code[i][6:0];
    end

    // Word-shape matching and payload selection; lane-4 forms accept ctl bit 4 either way
    always_comb begin
        w_oc0     = rs_to_cc_ocode(i_txd[7:0]);
        w_oc4     = rs_to_cc_ocode(i_txd[39:32]);
        w_d       = (i_txctl == 8'h00);
        w_c       = (i_txctl == 8'hFF) && (&w_cc_ok);
        w_lo4     = ({i_txctl[7:5], i_txctl[3:0]} == 7'h0F) && (&w_cc_ok[3:0]);
        w_o4      = w_lo4 && (i_txd[39:32] == RS_SEQ);
        w_s4      = w_lo4 && (i_txd[39:32] == RS_START);
        w_o0      = (i_txctl == 8'hF1) && (i_txd[7:0] == RS_SEQ) && (&w_cc_ok[7:4]);
        w_o0o4    = (i_txctl == 8'h11) && (i_txd[7:0] == RS_SEQ) && (i_txd[39:32] == RS_SEQ);
        w_o0s4    = (i_txctl == 8'h11) && (i_txd[7:0] == RS_SEQ) && (i_txd[39:32] == RS_START);
        w_s0      = (i_txctl == 8'h01) && (i_txd[7:0] == RS_START);
        o_type    = w_d ? T_D
                  : (w_c || w_o4 || w_o0 || w_o0o4) ? T_C
                  : (w_s0 || w_s4 || w_o0s4) ? T_S
                  : w_t_ok ? T_T : T_E;
        o_header  = w_d ? SYNC_DATA : SYNC_CTRL;
        o_payload = w_d    ? i_txd
                  : w_c    ? {w_cc, BT_IDLE}
                  : w_o4   ? {i_txd[63:40], w_oc4, w_cc[27:0], BT_O4}
                  : w_s4   ? {i_txd[63:40], 4'h0, w_cc[27:0], BT_S4}
                  : w_o0   ? {w_cc[55:28], w_oc0, i_txd[31:8], BT_O0}
                  : w_o0o4 ? {i_txd[63:40], w_oc4, w_oc0, i_txd[31:8], BT_O0O4}
                  : w_o0s4 ? {i_txd[63:40], 4'h0, w_oc0, i_txd[31:8], BT_O0S4}
                  : w_s0   ? {i_txd[63:8], BT_S0}
                  : w_t_ok ? w_t_pl : EBLOCK_T;
    end

endmodule

// File: rtl/encode_6466b.sv
// encode_6466b: 64b/66b TX encoder with legality state machine; ENCODE_ERR_CNT_EN adds o_err_count
module encode_6466b
    import code_defs_pkg::*;
#(
    parameter int ERR_CNT_WIDTH = 16
)
(
    input  logic        i_txc,
    input  logic        i_reset_n,
    input  logic        i_init_done,
    input  logic [63:0] i_txd,
    input  logic [7:0]  i_txctl,
    input  logic        i_tx_ready,
    output logic        o_tx_ready,
    output logic [63:0] o_txd,
    output logic [1:0]  o_tx_header,
    output logic        o_tx_valid
`ifdef ENCODE_ERR_CNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
`endif
);

    t_type_t     w_type;
    logic [63:0] w_payload;
    logic [1:0]  w_header;
    logic        w_legal;
    tx_state_t   w_next;
    tx_state_t   r_state;
    logic [63:0] r_txd;
    logic [1:0]  r_hdr;
    logic        r_valid;

    encode_6466b_classify u_classify (
        .i_txd     (i_txd),
        .i_txctl   (i_txctl),
        .o_type    (w_type),
        .o_payload (w_payload),
        .o_header  (w_header)
    );

    always_comb begin
        w_legal = (r_state == TX_D) ? (w_type == T_D || w_type == T_T)
                : (r_state == TX_E) ? (w_type != T_S && w_type != T_E)
                : (w_type == T_C || w_type == T_S);
        w_next  = !w_legal ? TX_E
                : (w_type == T_C) ? TX_C
                : (w_type == T_T) ? TX_T : TX_D;
    end

    always_ff @(posedge i_txc) begin
        if (!i_reset_n) begin
            r_state <= TX_INIT;
            r_txd   <= {56'h0, BT_IDLE};
            r_hdr   <= SYNC_CTRL;
            r_valid <= 1'b0;
        end else if (!i_init_done) begin
            r_state <= TX_INIT;
        end else if (i_tx_ready) begin
            r_state <= w_next;
            r_txd   <= w_legal ? w_payload : EBLOCK_T;
            r_hdr   <= w_legal ? w_header : SYNC_CTRL;
            r_valid <= 1'b1;
        end
    end

    assign o_tx_ready  = i_tx_ready;
    assign o_txd       = r_txd;
    assign o_tx_header = r_hdr;
    assign o_tx_valid  = r_valid;

`ifdef ENCODE_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    always_ff @(posedge i_txc) begin
        if (!i_reset_n)
            r_err_count <= '0;
        else if (i_init_done && i_tx_ready && !w_legal && !(&r_err_count))
            r_err_count <= r_err_count + 1'b1;
    end

    assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_encode_6466b.sv
// tb_encode_6466b: directed vectors with hand-computed blocks, scoreboard queue and decoupled monitor
module tb_encode_6466b;

    localparam logic [63:0] EB   = 64'h3C78F1E3C78F1E1E;
    localparam logic [63:0] IDLE = 64'h0707070707070707;
    localparam logic [63:0] S0W  = 64'hD5555555555555FB;
    localparam logic [63:0] DW1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] DW2  = 64'hFEDCBA9876543210;
    localparam logic [1:0]  HC   = 2'b10;
    localparam logic [1:0]  HD   = 2'b01;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_done = 1'b0;
    logic        tx_ready = 1'b0;
    logic [63:0] txd = 64'h0;
    logic [7:0]  txctl = 8'h00;
    logic        o_tx_ready;
    logic [63:0] o_txd;
    logic [1:0]  o_tx_header;
    logic        o_tx_valid;
`ifdef ENCODE_ERR_CNT_EN
    logic [1:0]  err_count;
`endif

    typedef struct {
        logic [65:0] v;
        string       n;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        adv_q = 1'b0;
    logic [66:0] last = '0;
    bit          have_last = 1'b0;

    always #5 clk = ~clk;

    encode_6466b #(.ERR_CNT_WIDTH(2)) dut (
        .i_txc       (clk),
        .i_reset_n   (reset_n),
        .i_init_done (init_done),
        .i_txd       (txd),
        .i_txctl     (txctl),
        .i_tx_ready  (tx_ready),
        .o_tx_ready  (o_tx_ready),
        .o_txd       (o_txd),
        .o_tx_header (o_tx_header),
        .o_tx_valid  (o_tx_valid)
`ifdef ENCODE_ERR_CNT_EN
        ,
        .o_err_count (err_count)
`endif
    );

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic send(input string name, input logic [63:0] d, input logic [7:0] c,
                        input logic [1:0] h, input logic [63:0] p);
        exp_t e;
        e.v = {h, p};
        e.n = name;
        exp_q.push_back(e);
        txd      = d;
        txctl    = c;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
    endtask

    task automatic pause(input int n, input logic [63:0] d, input logic [7:0] c);
        txd      = d;
        txctl    = c;
        tx_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {o_tx_valid, o_tx_header, o_txd}, {1'b0, HC, 64'h1E});
        reset_n = 1'b1;
    endtask

    always @(posedge clk) adv_q <= reset_n & init_done & tx_ready;

    always @(negedge clk) begin
        exp_t e;
        chk("tx_ready_pass", {66'd0, o_tx_ready}, {66'd0, tx_ready});
        if (adv_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_block: got %h expected none", {o_tx_header, o_txd});
            end else begin
                e = exp_q.pop_front();
                last = {1'b1, e.v};
                have_last = 1'b1;
                chk(e.n, {o_tx_valid, o_tx_header, o_txd}, last);
            end
        end else if (have_last) begin
            chk("hold", {o_tx_valid, o_tx_header, o_txd}, last);
        end
        if (!reset_n) have_last = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {o_tx_valid, o_tx_header, o_txd}, {1'b0, HC, 64'h1E});
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        init_done = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_before_advance", {66'd0, o_tx_valid}, 67'd0);
        repeat (4) send("idle", IDLE, 8'hFF, HC, 64'h1E);
        send("s0", S0W, 8'h01, HC, 64'hD555555555555578);
        send("d1", DW1, 8'h00, HD, DW1);
        send("d2", DW2, 8'h00, HD, DW2);
        send("t3", 64'h07070707FD332211, 8'hF8, HC, 64'h00000000332211B4);
        send("idle_after_t", IDLE, 8'hFF, HC, 64'h1E);
        send("d_in_c", 64'h1111111111111111, 8'h00, HC, EB);
        send("s_in_e", S0W, 8'h01, HC, EB);
        send("c_exit_e", IDLE, 8'hFF, HC, 64'h1E);
        send("bad_ctl", S0W, 8'h03, HC, EB);
        send("bad_char", 64'h0707070755070707, 8'hFF, HC, EB);
        send("d_exit_e", 64'h1111111111111111, 8'h00, HD, 64'h1111111111111111);
        send("t7_after_d", 64'hFD77665544332211, 8'h80, HC, 64'h77665544332211FF);
        send("t_in_t", 64'h07070707070707FD, 8'hFF, HC, EB);
        send("c_after_e", IDLE, 8'hFF, HC, 64'h1E);
        send("p_s0", S0W, 8'h01, HC, 64'hD555555555555578);
        send("p_d1", DW1, 8'h00, HD, DW1);
        pause(3, DW2, 8'h00);
        send("p_d2", DW2, 8'h00, HD, DW2);
        send("p_t0", 64'h07070707070707FD, 8'hFF, HC, 64'h87);
        send("p_idle", IDLE, 8'hFF, HC, 64'h1E);
        send("o4", 64'hCCBBAA9C07070707, 8'h0F, HC, 64'hCCBBAA000000002D);
        send("o4_err_lane0", 64'hCCBBAA9C070707FE, 8'h0F, HC, 64'hCCBBAA0000001E2D);
        send("o0", 64'h070707073322119C, 8'hF1, HC, 64'h000000003322114B);
        send("o0o4", 64'h6655449C3322119C, 8'h11, HC, 64'h6655440033221155);
        send("s4", 64'h555555FB07070707, 8'h0F, HC, 64'h5555550000000033);
        send("t0", 64'h07070707070707FD, 8'hFF, HC, 64'h87);
        send("o0s4", 64'h555555FB3322119C, 8'h11, HC, 64'h5555550033221166);
        send("d_o0s4", DW1, 8'h00, HD, DW1);
        send("t1", 64'h070707070707FD11, 8'hFE, HC, 64'h1199);
        send("s0_t2", S0W, 8'h01, HC, 64'hD555555555555578);
        send("t2", 64'h0707070707FD2211, 8'hFC, HC, 64'h2211AA);
        send("s0_t3", S0W, 8'h01, HC, 64'hD555555555555578);
        send("t3b", 64'h07070707FD332211, 8'hF8, HC, 64'h332211B4);
        send("s0_t4", S0W, 8'h01, HC, 64'hD555555555555578);
        send("t4", 64'h070707FD44332211, 8'hF0, HC, 64'h44332211CC);
        send("s0_t5", S0W, 8'h01, HC, 64'hD555555555555578);
        send("t5_err_lane7", 64'hFE07FD5544332211, 8'hE0, HC, 64'h3C005544332211D2);
        send("s0_t6", S0W, 8'h01, HC, 64'hD555555555555578);
        send("t6", 64'h07FD665544332211, 8'hC0, HC, 64'h665544332211E1);
        send("s0_t7", S0W, 8'h01, HC, 64'hD555555555555578);
        send("t7", 64'hFD77665544332211, 8'h80, HC, 64'h77665544332211FF);
        send("r_s0", S0W, 8'h01, HC, 64'hD555555555555578);
        send("r_d1", DW1, 8'h00, HD, DW1);
        do_reset();
        send("d_after_reset", DW1, 8'h00, HC, EB);
        send("c_after_reset", IDLE, 8'hFF, HC, 64'h1E);
        send("i_s0", S0W, 8'h01, HC, 64'hD555555555555578);
        init_done = 1'b0;
        txd       = DW1;
        txctl     = 8'h00;
        tx_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tx_ready  = 1'b0;
        init_done = 1'b1;
        send("d_after_init_drop", DW1, 8'h00, HC, EB);
        send("c_after_init_drop", IDLE, 8'hFF, HC, 64'h1E);
`ifdef ENCODE_ERR_CNT_EN
        do_reset();
        chk("err_cnt_reset", {65'd0, err_count}, 67'd0);
        send("e1", S0W, 8'h03, HC, EB);
        chk("err_cnt_1", {65'd0, err_count}, 67'd1);
        send("e2", S0W, 8'h03, HC, EB);
        chk("err_cnt_2", {65'd0, err_count}, 67'd2);
        send("e3", S0W, 8'h03, HC, EB);
        chk("err_cnt_3", {65'd0, err_count}, 67'd3);
        send("e4", S0W, 8'h03, HC, EB);
        chk("err_cnt_sat4", {65'd0, err_count}, 67'd3);
        send("e5", S0W, 8'h03, HC, EB);
        chk("err_cnt_sat5", {65'd0, err_count}, 67'd3);
        do_reset();
        chk("err_cnt_cleared", {65'd0, err_count}, 67'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
